// File: rtl/decoder_sweep_ctrl.sv
// Sweeps codes 0..15 into a 4x16 decoder and scores each response against one-hot.
// Latency: 16*(SETTLE_CYCLES+2) cycles per sweep plus one DONE cycle; abort returns to IDLE in one cycle.
module decoder_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  d_in,
    input  logic [15:0] d_out,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        pass,
    output logic [4:0]  fail_count,
    output logic [15:0] fail_map,
    output logic        first_fail_valid,
    output logic [3:0]  first_fail_code
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  code;
    logic [3:0]  settle_cnt;
    logic        aborted_q;
    logic [15:0] expected;
    logic        mismatch;
    logic        abort_hit;
    logic        last_code;

    assign expected  = 16'h0001 << code;
    assign mismatch  = (d_out != expected);
    assign abort_hit = (state != ST_IDLE) && abort;
    assign last_code = (code == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_WAIT;
            ST_WAIT:  if (settle_cnt <= 4'd1) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = last_code ? ST_DONE : ST_APPLY;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Abort overrides every non-IDLE transition, including the CHECK result.
        if (abort_hit) state_nxt = ST_IDLE;
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE) && !abort;
        aborted = aborted_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code             <= 4'd0;
            settle_cnt       <= 4'd0;
            d_in             <= 4'd0;
            aborted_q        <= 1'b0;
            pass             <= 1'b0;
            fail_count       <= 5'd0;
            fail_map         <= 16'h0000;
            first_fail_valid <= 1'b0;
            first_fail_code  <= 4'd0;
        end else begin
            aborted_q <= 1'b0;
            if (abort_hit) begin
                aborted_q <= 1'b1;
                d_in      <= 4'd0;
                pass      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            code             <= 4'd0;
                            d_in             <= 4'd0;
                            pass             <= 1'b0;
                            fail_count       <= 5'd0;
                            fail_map         <= 16'h0000;
                            first_fail_valid <= 1'b0;
                            first_fail_code  <= 4'd0;
                        end
                    end
                    ST_APPLY: begin
                        settle_cnt <= SETTLE_LOAD;
                    end
                    ST_WAIT: begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                    ST_CHECK: begin
                        if (mismatch) begin
                            fail_map[code] <= 1'b1;
                            fail_count     <= fail_count + 5'd1;
                            if (!first_fail_valid) begin
                                first_fail_code  <= code;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (last_code) begin
                            // Verdict is published together with the done pulse.
                            pass <= (fail_count == 5'd0) && !mismatch;
                        end else begin
                            code <= code + 4'd1;
                            d_in <= code + 4'd1;
                        end
                    end
                    ST_DONE: begin
                        d_in <= 4'd0;
                    end
                    default: begin
                        d_in <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/decoder_sweep_ctrl.md
DECODER_SWEEP_CTRL -- requirements
Module: decoder_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, cycles d_in is held before d_out is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  begin a 16-code sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate sweep; sampled in every non-IDLE state.
REQ-006 d_in  output  4  registered code driven to the 4x16 decoder under test.
REQ-007 d_out  input  16  decoder response for the current d_in.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse on sweep completion.
REQ-010 aborted  output  1  one-cycle pulse when a sweep is terminated by abort.
REQ-011 pass  output  1  high when the last completed sweep had zero failures.
REQ-012 fail_count  output  5  number of failing codes in the current/last sweep, 0..16.
REQ-013 fail_map  output  16  bit i set when code i failed.
REQ-014 first_fail_valid  output  1  high once any code has failed in the current/last sweep.
REQ-015 first_fail_code  output  4  lowest failing code; valid only with first_fail_valid.

Function
REQ-016 FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
REQ-017 IDLE with start=1: code<=0, fail_count/fail_map/first_fail_valid/first_fail_code/pass cleared, next APPLY.
REQ-018 IDLE with start=0: remain IDLE; result outputs hold.
REQ-019 APPLY (1 cycle): d_in=code, settle counter loaded with SETTLE_CYCLES, next WAIT.
REQ-020 WAIT: counter decrements each cycle; after SETTLE_CYCLES cycles in WAIT, next CHECK.
REQ-021 CHECK (1 cycle): expected = 16'h0001 shifted left by code; mismatch when d_out != expected, including zero-hot and multi-hot outputs.
REQ-022 CHECK on mismatch: fail_map[code]<=1, fail_count<=fail_count+1; if first_fail_valid=0, first_fail_code<=code and first_fail_valid<=1.
REQ-023 CHECK exit: code<15 -> code<=code+1, next APPLY; code=15 -> next DONE (no 4-bit wrap to 0 continues the sweep).
REQ-024 DONE (1 cycle): done=1, pass=(fail_count==0), d_in<=0, next IDLE; start ignored in DONE.
REQ-025 Per-code cost SETTLE_CYCLES+2 cycles; done high in the cycle after edge k+16*(SETTLE_CYCLES+2), k = edge sampling start (SETTLE_CYCLES=1: 48 edges).
REQ-026 d_in stable for the whole APPLY..CHECK interval of each code.
REQ-027 abort=1 in APPLY/WAIT/CHECK/DONE: next IDLE, aborted=1 for one cycle, d_in<=0, done not asserted, pass<=0; partial fail results hold; CHECK update of that cycle is discarded.
REQ-028 abort and start both high in IDLE: start wins; abort ignored in IDLE.
REQ-029 start held continuously: new sweep begins from the IDLE cycle following each DONE.
REQ-030 fail_count never exceeds 16; no saturation logic beyond the 5-bit width is required.

Reset
REQ-031 rst=1 at any edge, including mid-sweep: state IDLE, code 0, d_in 0, busy 0, done 0, aborted 0, pass 0, fail_count 0, fail_map 0, first_fail_valid 0, first_fail_code 0.
REQ-032 rst has priority over start and abort in the same cycle.

Verification
REQ-033 Ideal decoder model, SETTLE_CYCLES=1, one start pulse -> done 48 edges later, pass=1, fail_count=0, fail_map=16'h0000, first_fail_valid=0.
REQ-034 Decoder model clearing d_in[2] when d_in[3]=1 -> fail_map=16'hF000, fail_count=4, first_fail_code=12, first_fail_valid=1, pass=0.
REQ-035 d_out tied 16'h0000 -> fail_map=16'hFFFF, fail_count=16, first_fail_code=0, pass=0.
REQ-036 abort asserted while code=5 in WAIT -> aborted pulse next cycle, busy=0, d_in=0, done never pulses, fail_count reflects codes 0..4 only.
REQ-037 rst asserted while code=9 -> all outputs at REQ-031 values next cycle; subsequent start runs a full clean sweep.
REQ-038 SETTLE_CYCLES=3, start held high for 200 cycles -> done pulses every 82 cycles (80 sweep + DONE + IDLE), start during busy ignored.
